pd_input_arbiter: RTL
=====================

// Module: pd_input_arbiter
// PURPOSE
//  Arbiter/sequencer in front of the packet-identifier pipeline register (pd stage). Two upstream
//  beat sources share the single pd register; one packet at a time, round-robin between packets.
//  Block drives the register's data/DK inputs and its hold, and tracks register occupancy (pd_valid).
//  Grant is locked for a whole packet, until the beat flagged last is accepted.
// PARAMETERS
//  DATA_W         512   beat width in bits
//  DK_W           64    data/K flag width, one bit per byte (DATA_W/8)
//  MAX_PKT_BEATS  1024  watchdog limit in beats per packet (used only with PD_ARB_WATCHDOG_EN)
// PORTS
//  clk         in   1       clock
//  rst         in   1       async reset, active-low
//  req0_valid  in   1       source 0 beat valid
//  req0_data   in   DATA_W  source 0 beat
//  req0_dk     in   DK_W    source 0 data/K flags
//  req0_last   in   1       source 0 end-of-packet beat
//  req0_ready  out  1       source 0 beat accepted this cycle when valid&ready
//  req1_*      --   --      identical set for source 1
//  pd_ready    in   1       downstream consumes pd register content this cycle
//  pd_data_in  out  DATA_W  to pd register data input (muxed from granted source, 0 if none)
//  pd_dk_in    out  DK_W    to pd register DK input (same mux)
//  hld_pd      out  1       hold to pd register; 1 = keep current content
//  pd_valid    out  1       pd register holds a valid beat
//  gnt         out  2       one-hot current grant (2'b00 in IDLE)
//  wdog_err    out  1       one-cycle pulse on watchdog force-release
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, gnt=0, rr_ptr=0 (source 0 preferred), pd_valid=0,
//   hld_pd=0, req*_ready=0, wdog_err=0, beat counter=0. Reset mid-packet drops the packet silently.
//  FSM IDLE/GNT0/GNT1, registered.
//   IDLE: if only reqN_valid -> GNTN; if both -> GNT[rr_ptr]; none -> stay. No beat accepted in IDLE.
//   GNTN: accept = reqN_valid & reqN_ready. accept & reqN_last -> IDLE, rr_ptr <= ~N.
//  hld_pd = pd_valid & ~pd_ready (combinational). reqN_ready = gnt[N] & ~hld_pd; other source 0.
//  pd_valid next: if ~hld_pd then accept else pd_valid (hold).
//  Register loads whenever hld_pd=0; pd_data_in/pd_dk_in = granted source bus, all-zero in IDLE;
//   loads with pd_valid=0 are bubbles and carry no meaning.
//  Latency: request in IDLE at cycle N -> gnt at N+1, first beat accepted N+1 (if ~hld_pd),
//   valid at pd register output N+2. One IDLE bubble cycle between consecutive packets.
//  Mid-packet gap (granted valid=0): grant kept, bubble loaded, pd_valid=0.
//  Downstream stall: hld_pd=1 holds register, reqN_ready=0; no beat lost or duplicated.
//  last beat under stall: accepted only when ready=1; FSM leaves GNTN on that acceptance cycle.
//  Non-granted source valid is ignored and must be held by the source (no drop).
// CONFIGURATION
//  PD_ARB_WATCHDOG_EN defined: counter of accepted beats per packet, cleared on entry to GNTx.
//   When counter reaches MAX_PKT_BEATS accepted beats with no last: FSM -> IDLE next cycle,
//   rr_ptr flips, wdog_err=1 for one cycle; remaining beats of that packet compete as a new packet.
//   Beat with last at exactly MAX_PKT_BEATS is normal end (no error).
//  Not defined: no counter; grant held until last indefinitely; wdog_err tied 0.
// TESTING
//  1 Reset: rst=0 with both valid -> gnt=0, pd_valid=0, hld_pd=0, ready=0; release -> gnt=01 next clk.
//  2 Single 4-beat packet on src0, pd_ready=1 -> beats D0..D3 at pd output cycles 2..5, gnt back to 00.
//  3 Both sources continuous 2-beat packets -> order src0,src1,src0,... with one idle cycle between.
//  4 pd_ready=0 for 3 cycles mid-packet -> hld_pd=1, data_out stable, req0_ready=0, no beat lost.
//  5 src0 valid gap of 2 cycles mid-packet -> gnt stays 01, pd_valid=0 for 2 cycles, src1 blocked.
//  6 WATCHDOG_EN, MAX_PKT_BEATS=8, 10-beat packet w/o last -> wdog_err pulse after 8th beat, grant to src1.

Source files
------------

// File: rtl/pd_input_arbiter.sv
// Two-source packet arbiter feeding the pd pipeline register; round-robin per packet, grant locked until last.
// Optional per-packet beat watchdog enabled by defining PD_ARB_WATCHDOG_EN.
module pd_input_arbiter #(
   parameter int DATA_W        = 512,
   parameter int DK_W          = 64,
   parameter int MAX_PKT_BEATS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [DK_W-1:0]   req0_dk,
   input  logic              req0_last,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   input  logic [DK_W-1:0]   req1_dk,
   input  logic              req1_last,
   output logic              req1_ready,
   input  logic              pd_ready,
   output logic [DATA_W-1:0] pd_data_in,
   output logic [DK_W-1:0]   pd_dk_in,
   output logic              hld_pd,
   output logic              pd_valid,
   output logic [1:0]        gnt,
   output logic              wdog_err
);

   // state   | meaning
   // ST_IDLE | no packet owns the pd register; arbitrate on valid
   // ST_GNT0 | source 0 owns the register until its last beat is accepted
   // ST_GNT1 | source 1 owns the register until its last beat is accepted
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   state_t state;
   logic   rr_ptr;
   logic   accept0;
   logic   accept1;
   logic   accept;
   logic   accept_last;

   assign hld_pd      = pd_valid & ~pd_ready;
   assign req0_ready  = gnt[0] & ~hld_pd;
   assign req1_ready  = gnt[1] & ~hld_pd;
   assign accept0     = req0_valid & req0_ready;
   assign accept1     = req1_valid & req1_ready;
   assign accept      = accept0 | accept1;
   assign accept_last = (accept0 & req0_last) | (accept1 & req1_last);

   // Idle loads a zero bus; it is a bubble because pd_valid stays low.
   always_comb begin
      pd_data_in = '0;
      pd_dk_in   = '0;
      if (gnt[0]) begin
         pd_data_in = req0_data;
         pd_dk_in   = req0_dk;
      end else if (gnt[1]) begin
         pd_data_in = req1_data;
         pd_dk_in   = req1_dk;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pd_valid <= 1'b0;
      end else if (!hld_pd) begin
         pd_valid <= accept;
      end
   end

`ifdef PD_ARB_WATCHDOG_EN
   localparam int CNT_W = $clog2(MAX_PKT_BEATS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_BEATS - 1);

   logic [CNT_W-1:0] beat_cnt;
   logic             wdog_hit;

   // Fires on the accept that completes MAX_PKT_BEATS beats without a last flag.
   assign wdog_hit = accept & ~accept_last & (beat_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         gnt      <= 2'b00;
         rr_ptr   <= 1'b0;
         beat_cnt <= '0;
         wdog_err <= 1'b0;
      end else begin
         wdog_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               beat_cnt <= '0;
               if (req0_valid && (!req1_valid || !rr_ptr)) begin
                  state <= ST_GNT0;
                  gnt   <= 2'b01;
               end else if (req1_valid) begin
                  state <= ST_GNT1;
                  gnt   <= 2'b10;
               end
            end
            ST_GNT0, ST_GNT1: begin
               if (accept) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
               if (accept_last || wdog_hit) begin
                  state    <= ST_IDLE;
                  gnt      <= 2'b00;
                  rr_ptr   <= (state == ST_GNT0);
                  wdog_err <= wdog_hit;
               end
            end
            default: begin
               state <= ST_IDLE;
               gnt   <= 2'b00;
            end
         endcase
      end
   end
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         gnt    <= 2'b00;
         rr_ptr <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req0_valid && (!req1_valid || !rr_ptr)) begin
                  state <= ST_GNT0;
                  gnt   <= 2'b01;
               end else if (req1_valid) begin
                  state <= ST_GNT1;
                  gnt   <= 2'b10;
               end
            end
            ST_GNT0, ST_GNT1: begin
               if (accept_last) begin
                  state  <= ST_IDLE;
                  gnt    <= 2'b00;
                  rr_ptr <= (state == ST_GNT0);
               end
            end
            default: begin
               state <= ST_IDLE;
               gnt   <= 2'b00;
            end
         endcase
      end
   end

   assign wdog_err = 1'b0;
`endif

endmodule
